// File: rtl/spike_address_dispatcher_if.sv
// Source-address bus from the spike dispatcher to the MAC units of the next layer.
// Carries the valid/ready address handshake and the timestep-boundary clear pulse.
interface spike_address_dispatcher_if #(
    parameter int unsigned ADDR_BITS = 12
);
    logic [ADDR_BITS-1:0] source_address;
    logic                 address_valid;
    logic                 address_ready;
    logic                 clear;

    modport master (
        output source_address,
        output address_valid,
        output clear,
        input  address_ready
    );

    modport slave (
        input  source_address,
        input  address_valid,
        input  clear,
        output address_ready
    );
endinterface

// File: rtl/spike_address_dispatcher.sv
// Captures spike flags at each timestep end and streams one source address per firing neuron,
// lowest index first, followed by a one-cycle clear. Optional shadow buffer: SPIKE_DOUBLE_BUFFER_EN.
module spike_address_dispatcher #(
    parameter int unsigned NUM_NEURONS  = 10,
    parameter int unsigned ADDR_BITS    = 12,
    parameter int unsigned BASE_ADDRESS = 0
) (
    input  logic                       CLK,
    input  logic                       RESETN,
    input  logic                       timestep_end,
    input  logic [NUM_NEURONS-1:0]     spikes_in,
    spike_address_dispatcher_if.master bus,
    output logic                       busy,
    output logic [6:0]                 spike_count,
    output logic                       overrun
);

    localparam int unsigned IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int unsigned CNT_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CLEAR = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_NEURONS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   valid_q, valid_d;
    logic                   clear_q, clear_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       spike_count_q, spike_count_d;
    logic                   overrun_q, overrun_d;
    logic [NUM_NEURONS-1:0] low_bit;
`ifdef SPIKE_DOUBLE_BUFFER_EN
    logic [NUM_NEURONS-1:0] shadow_q, shadow_d;
    logic                   shadow_full_q, shadow_full_d;
`endif

    // Index of the lowest set bit; the downward scan lets the lowest index win.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_NEURONS-1:0] p);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (p[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    assign low_bit = pending_q & (~pending_q + NUM_NEURONS'(1));

    // Next-state, pending/counter update and registered-output precompute.
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        count_d       = count_q;
        spike_count_d = spike_count_q;
        overrun_d     = overrun_q;
`ifdef SPIKE_DOUBLE_BUFFER_EN
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
`endif

        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (timestep_end) begin
                    pending_d = spikes_in;
                    state_d   = (|spikes_in) ? SEND : CLEAR;
                end
            end
            SEND: begin
                if (valid_q && bus.address_ready) begin
                    pending_d = pending_q & ~low_bit;
                    count_d   = count_q + CNT_W'(1);
                    if (pending_d == '0) state_d = CLEAR;
                end
            end
            CLEAR: begin
`ifdef SPIKE_DOUBLE_BUFFER_EN
                if (shadow_full_q) begin
                    pending_d     = shadow_q;
                    count_d       = '0;
                    shadow_full_d = 1'b0;
                    state_d       = (|shadow_q) ? SEND : CLEAR;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        // A timestep boundary seen while busy either parks in the shadow or is dropped.
        if (timestep_end && (state_q != IDLE)) begin
`ifdef SPIKE_DOUBLE_BUFFER_EN
            if (shadow_full_q) begin
                overrun_d = 1'b1;
            end else begin
                shadow_d      = spikes_in;
                shadow_full_d = 1'b1;
            end
`else
            overrun_d = 1'b1;
`endif
        end

        if (state_d == CLEAR) spike_count_d = count_d;

        valid_d = (state_d == SEND);
        clear_d = (state_d == CLEAR);
        busy_d  = (state_d != IDLE);
        addr_d  = valid_d ? (ADDR_BITS'(BASE_ADDRESS) + ADDR_BITS'(lowest_idx(pending_d)))
                          : '0;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            count_q       <= '0;
            addr_q        <= '0;
            valid_q       <= 1'b0;
            clear_q       <= 1'b0;
            busy_q        <= 1'b0;
            spike_count_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            count_q       <= count_d;
            addr_q        <= addr_d;
            valid_q       <= valid_d;
            clear_q       <= clear_d;
            busy_q        <= busy_d;
            spike_count_q <= spike_count_d;
            overrun_q     <= overrun_d;
        end
    end

`ifdef SPIKE_DOUBLE_BUFFER_EN
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
        end
    end
`endif

    assign bus.source_address = addr_q;
    assign bus.address_valid  = valid_q;
    assign bus.clear          = clear_q;
    assign busy               = busy_q;
    assign spike_count        = spike_count_q;
    assign overrun            = overrun_q;

endmodule

// File: tb/tb_spike_address_dispatcher.sv
// Bench for spike_address_dispatcher: two instances (base 0 and base 13) share stimulus; an
// expected-event scoreboard built from the spike vectors checks the address/clear streams.
module tb_spike_address_dispatcher;

    localparam int unsigned N  = 10;
    localparam int unsigned AW = 12;
    localparam int          CLR_TAG = 1000;

    logic         CLK = 1'b0;
    logic         RESETN;
    logic         timestep_end;
    logic         address_ready;
    logic [N-1:0] spikes_in;

    logic         busy0, busy13, ov0, ov13;
    logic [6:0]   cnt0, cnt13;

    int checks = 0;
    int errors = 0;
    int q [2][$];

    logic [1:0]    v, c, b, o;
    logic [AW-1:0] a [2];
    logic [6:0]    sc [2];
    logic [1:0]    hold;
    logic [AW-1:0] haddr [2];

    always #5 CLK = ~CLK;

    spike_address_dispatcher_if #(.ADDR_BITS(AW)) bus0 ();
    spike_address_dispatcher_if #(.ADDR_BITS(AW)) bus13 ();

    assign bus0.address_ready  = address_ready;
    assign bus13.address_ready = address_ready;

    spike_address_dispatcher #(.NUM_NEURONS(N), .ADDR_BITS(AW), .BASE_ADDRESS(0)) dut0 (
        .CLK(CLK), .RESETN(RESETN), .timestep_end(timestep_end), .spikes_in(spikes_in),
        .bus(bus0), .busy(busy0), .spike_count(cnt0), .overrun(ov0)
    );

    spike_address_dispatcher #(.NUM_NEURONS(N), .ADDR_BITS(AW), .BASE_ADDRESS(13)) dut13 (
        .CLK(CLK), .RESETN(RESETN), .timestep_end(timestep_end), .spikes_in(spikes_in),
        .bus(bus13), .busy(busy13), .spike_count(cnt13), .overrun(ov13)
    );

    always_comb begin
        v     = {bus13.address_valid, bus0.address_valid};
        c     = {bus13.clear, bus0.clear};
        b     = {busy13, busy0};
        o     = {ov13, ov0};
        a[0]  = bus0.source_address;
        a[1]  = bus13.source_address;
        sc[0] = cnt0;
        sc[1] = cnt13;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected transactions of one timestep: ascending addresses, then a clear tagged with the count.
    task automatic push_ts(input logic [N-1:0] s);
        for (int d = 0; d < 2; d++) begin
            int base = (d == 0) ? 0 : 13;
            int n = 0;
            for (int i = 0; i < int'(N); i++) begin
                if (s[i]) begin
                    q[d].push_back(base + i);
                    n++;
                end
            end
            q[d].push_back(CLR_TAG + n);
        end
    endtask

    // Stream monitor: every handshake and clear must match the scoreboard; stalled beats must hold.
    always @(negedge CLK) begin
        if (!RESETN) begin
            hold = 2'b00;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (hold[d]) begin
                    check("hold_valid", 32'(v[d]), 32'd1);
                    check("hold_addr", 32'(a[d]), 32'(haddr[d]));
                end
                if (v[d] && address_ready) begin
                    check("addr_expected", 32'(q[d].size() != 0), 32'd1);
                    if (q[d].size() != 0) check("addr_stream", 32'(a[d]), 32'(q[d].pop_front()));
                end
                if (c[d]) begin
                    check("clear_no_valid", 32'(v[d]), 32'd0);
                    check("clear_expected", 32'(q[d].size() != 0), 32'd1);
                    if (q[d].size() != 0)
                        check("clear_count", 32'(CLR_TAG + int'(sc[d])), 32'(q[d].pop_front()));
                end
                hold[d] = v[d] && !address_ready;
                haddr[d] = a[d];
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic fire(input logic [N-1:0] s, input bit model);
        spikes_in    = s;
        timestep_end = 1'b1;
        if (model) push_ts(s);
        cyc();
        timestep_end = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        int n = 0;
        while (n < budget && !(q[0].size() == 0 && q[1].size() == 0 && b == 2'b00)) begin
            if (rnd) address_ready = 1'($urandom_range(0, 1));
            cyc();
            n++;
        end
        check("wait_idle_bound", 32'(n < budget), 32'd1);
        address_ready = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_valid"}, 32'(v[d]), 32'd0);
            check({tag, "_addr"}, 32'(a[d]), 32'd0);
            check({tag, "_clear"}, 32'(c[d]), 32'd0);
            check({tag, "_busy"}, 32'(b[d]), 32'd0);
            check({tag, "_count"}, 32'(sc[d]), 32'd0);
            check({tag, "_overrun"}, 32'(o[d]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_a [3];
        logic [N-1:0] s;
        exp_a = '{0, 2, 5};
        hold = 2'b00;
        RESETN = 1'b0; timestep_end = 1'b0; address_ready = 1'b1; spikes_in = '0;
        #12;
        check_reset_outputs("reset");
        cyc();
        RESETN = 1'b1;
        cyc();

        // Three spikes, ready high: addresses on cycles 1..3, clear on 4, idle on 5.
        fire(10'b0000100101, 1'b1);
        for (int t = 1; t <= 5; t++) begin
            @(negedge CLK);
            check("t1_valid0", 32'(v[0]), 32'(t <= 3));
            check("t1_valid13", 32'(v[1]), 32'(t <= 3));
            check("t1_clear", 32'(c[0]), 32'(t == 4));
            check("t1_busy", 32'(b[0]), 32'(t <= 4));
            if (t <= 3) begin
                check("t1_addr0", 32'(a[0]), 32'(exp_a[t-1]));
                check("t1_addr13", 32'(a[1]), 32'(exp_a[t-1] + 13));
            end
            if (t == 4) begin
                check("t1_count0", 32'(sc[0]), 32'd3);
                check("t1_count13", 32'(sc[1]), 32'd3);
            end
            cyc();
        end

        // No spikes: clear on cycle 1, never valid, count zero.
        fire('0, 1'b1);
        @(negedge CLK);
        check("k0_clear", 32'(c[0]), 32'd1);
        check("k0_valid", 32'(v[0]), 32'd0);
        check("k0_count", 32'(sc[0]), 32'd0);
        cyc();
        @(negedge CLK);
        check("k0_idle", 32'(b), 32'd0);
        check("k0_clear_once", 32'(c), 32'd0);
        cyc();

        // First beat stalled for three cycles.
        address_ready = 1'b0;
        fire(10'b1000000001, 1'b1);
        for (int t = 1; t <= 7; t++) begin
            if (t == 4) address_ready = 1'b1;
            @(negedge CLK);
            check("stall_valid", 32'(v[0]), 32'(t <= 5));
            check("stall_clear", 32'(c[0]), 32'(t == 6));
            if (t <= 4) check("stall_addr_hold", 32'(a[0]), 32'd0);
            if (t == 5) begin
                check("stall_addr9", 32'(a[0]), 32'd9);
                check("stall_addr22", 32'(a[1]), 32'd22);
            end
            if (t == 6) check("stall_count", 32'(sc[0]), 32'd2);
            if (t == 7) check("stall_idle", 32'(b[0]), 32'd0);
            cyc();
        end

        // Second timestep arrives while the first is still being sent.
        fire(10'b1000000001, 1'b1);
`ifdef SPIKE_DOUBLE_BUFFER_EN
        fire(10'b0000001110, 1'b1);
`else
        fire(10'b0000001110, 1'b0);
`endif
        @(negedge CLK);
`ifdef SPIKE_DOUBLE_BUFFER_EN
        check("ovr_flag", 32'(o), 32'b00);
`else
        check("ovr_flag", 32'(o), 32'b11);
`endif
        cyc();
        wait_idle(100, 1'b0);
`ifdef SPIKE_DOUBLE_BUFFER_EN
        check("ovr_last_count", 32'(sc[0]), 32'd3);
        check("ovr_sticky", 32'(o), 32'b00);
`else
        check("ovr_last_count", 32'(sc[0]), 32'd2);
        check("ovr_sticky", 32'(o), 32'b11);
`endif

        // Reset in the middle of SEND drops everything and issues no clear.
        address_ready = 1'b0;
        fire(10'b0000010010, 1'b1);
        @(posedge CLK);
        #2;
        RESETN = 1'b0;
        q[0].delete();
        q[1].delete();
        #1;
        check_reset_outputs("midreset");
        cyc();
        cyc();
        check("midreset_no_clear", 32'(c), 32'd0);
        RESETN = 1'b1;
        address_ready = 1'b1;
        cyc();
        fire(10'b0000000011, 1'b1);
        @(negedge CLK);
        check("post_reset_addr", 32'(a[0]), 32'd0);
        check("post_reset_valid", 32'(v[0]), 32'd1);
        cyc();
        wait_idle(100, 1'b0);
        check("post_reset_count", 32'(sc[1]), 32'd2);

        // Randomized timesteps with random backpressure.
        for (int it = 0; it < 30; it++) begin
            s = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
            if (it == 0) s = '1;
            address_ready = 1'($urandom_range(0, 1));
            fire(s, 1'b1);
            wait_idle(200, 1'b1);
            check("rand_count0", 32'(sc[0]), 32'($countones(s)));
        end

        cyc();
        check("final_queue0", 32'(q[0].size()), 32'd0);
        check("final_queue13", 32'(q[1].size()), 32'd0);
        check("final_overrun", 32'(o), 32'd0);
        check("final_idle", 32'(b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
